// File: rtl/axi_read_stream_if.sv
// Bundles the word-stream request/response side and the AXI4 read channels of axi_read_stream.
// READ_ERR exists only when AXI_READ_STREAM_ERR_EN is defined.
interface axi_read_stream_if;
    logic [31:0] READ_ADDR;
    logic [15:0] READ_COUNT;
    logic        READ_REQ;
    logic        READ_BUSY;
    logic [31:0] READ_DATA;
    logic        READ_VALID;
    logic        READ_READY;
    logic [31:0] M_ARADDR;
    logic [7:0]  M_ARLEN;
    logic [2:0]  M_ARSIZE;
    logic [1:0]  M_ARBURST;
    logic        M_ARVALID;
    logic        M_ARREADY;
    logic [31:0] M_RDATA;
    logic [1:0]  M_RRESP;
    logic        M_RLAST;
    logic        M_RVALID;
    logic        M_RREADY;
`ifdef AXI_READ_STREAM_ERR_EN
    logic        READ_ERR;
`endif

    // Handshakes: READ_REQ/READ_BUSY accepts when REQ=1 and BUSY=0; READ_VALID/READ_READY and
    // M_ARVALID/M_ARREADY transfer on a clock edge where both are high; M_RREADY is always 1.
    modport slave (
`ifdef AXI_READ_STREAM_ERR_EN
        output READ_ERR,
`endif
        input  READ_ADDR, READ_COUNT, READ_REQ, READ_READY,
        input  M_ARREADY, M_RDATA, M_RRESP, M_RLAST, M_RVALID,
        output READ_BUSY, READ_DATA, READ_VALID,
        output M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID, M_RREADY
    );

    modport master (
`ifdef AXI_READ_STREAM_ERR_EN
        input  READ_ERR,
`endif
        output READ_ADDR, READ_COUNT, READ_REQ, READ_READY,
        output M_ARREADY, M_RDATA, M_RRESP, M_RLAST, M_RVALID,
        input  READ_BUSY, READ_DATA, READ_VALID,
        input  M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID, M_RREADY
    );
endinterface

// File: rtl/axi_read_stream.sv
// Splits word-count read requests into 4 KB-safe AXI4 INCR bursts and streams the beats out of a FWFT FIFO.
// Optional macro AXI_READ_STREAM_ERR_EN adds a sticky READ_ERR flag for SLVERR/DECERR beats.
module axi_read_stream #(
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 512
) (
    input  logic              CLK,
    input  logic              RST,
    axi_read_stream_if.slave  bus,
    output logic [1:0]        dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, ADDR = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   rem_q, rem_d;
    logic [7:0]    arlen_q, arlen_d;
    logic [RW-1:0] resv_q, resv_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [31:0]   mem [FIFO_DEPTH];

    logic          accept, push, pop, fits;
    logic [8:0]    burst_len, resv_inc;
    logic [16:0]   page_w, min_a, calc_len;
    logic          unused_bits;

    assign accept    = (state_q == IDLE) && bus.READ_REQ && !busy_q;
    assign push      = bus.M_RVALID;
    assign pop       = (cnt_q != '0) && bus.READ_READY;
    assign burst_len = {1'b0, arlen_q} + 9'd1;

    // Burst length is bounded by the words left, MAX_BURST and the words left in the 4 KB page.
    assign page_w   = 17'((13'h1000 - {1'b0, addr_q[11:0]}) >> 2);
    assign min_a    = ({1'b0, rem_q} < 17'(MAX_BURST)) ? {1'b0, rem_q} : 17'(MAX_BURST);
    assign calc_len = (min_a < page_w) ? min_a : page_w;
    assign fits     = (32'(resv_q) + 32'(calc_len)) <= 32'(FIFO_DEPTH);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        arlen_d  = arlen_q;
        resv_inc = 9'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = {bus.READ_ADDR[31:2], 2'b00};
                    rem_d  = bus.READ_COUNT;
                    if (bus.READ_COUNT != 16'd0) state_d = CALC;
                end
            end
            CALC: begin
                if (fits) begin
                    arlen_d  = 8'(calc_len - 17'd1);
                    resv_inc = calc_len[8:0];
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (bus.M_ARREADY) begin
                    addr_d  = addr_q + {21'd0, burst_len, 2'b00};
                    rem_d   = rem_q - {7'd0, burst_len};
                    state_d = (rem_q != {7'd0, burst_len}) ? CALC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d   = (state_d != IDLE);
        // Reservation covers FIFO contents plus beats still in flight, so M_RREADY can stay high.
        resv_d   = resv_q + RW'(resv_inc) - RW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + RW'(push) - RW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            arlen_q  <= '0;
            resv_q   <= '0;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            arlen_q  <= arlen_d;
            resv_q   <= resv_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr_q] <= bus.M_RDATA;
    end

    assign bus.READ_BUSY  = busy_q;
    assign bus.READ_VALID = (cnt_q != '0);
    assign bus.READ_DATA  = (cnt_q != '0) ? mem[rd_ptr_q] : 32'd0;
    assign bus.M_ARADDR   = addr_q;
    assign bus.M_ARLEN    = arlen_q;
    assign bus.M_ARSIZE   = 3'b010;
    assign bus.M_ARBURST  = 2'b01;
    assign bus.M_ARVALID  = (state_q == ADDR);
    assign bus.M_RREADY   = 1'b1;
    assign dbg_state      = state_q;

`ifdef AXI_READ_STREAM_ERR_EN
    logic err_q, err_d;

    // A bad beat arriving on the accept cycle takes priority over the clear.
    always_comb begin
        err_d = err_q;
        if (accept) err_d = 1'b0;
        if (bus.M_RVALID && bus.M_RRESP[1]) err_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.READ_ERR = err_q;
    assign unused_bits  = ^{bus.M_RLAST, bus.M_RRESP[0], bus.READ_ADDR[1:0], calc_len[16:9]};
`else
    assign unused_bits  = ^{bus.M_RLAST, bus.M_RRESP, bus.READ_ADDR[1:0], calc_len[16:9]};
`endif
endmodule

// File: tb/tb_axi_read_stream.sv
// Directed bench for axi_read_stream: table of requests with expected AR splits plus hand-written
// sequences for busy timing, zero length, ARREADY stall, backpressure, mid-burst reset and READ_ERR.
module tb_axi_read_stream;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;

  axi_read_stream_if bus();

  axi_read_stream #(.MAX_BURST(16), .FIFO_DEPTH(32)) dut (
    .CLK(clk), .RST(rst), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_addr[$];
  logic [7:0] obs_len[$];
  logic [31:0] beat_q[$];
  logic last_q[$];
  int ar_delay = 0;
  int inject_at = -1;
  int beats_fired = 0;
  logic hold_valid = 1'b0;
  logic [31:0] hold_addr;
  logic [7:0] hold_len;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] count;
    int n_ar;
    logic [31:0] ar_addr[3];
    logic [7:0] ar_len[3];
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive at posedge+1: request is accepted at the next edge.
  task automatic do_req(input logic [31:0] a, input logic [15:0] n);
    logic [31:0] base;
    base = {a[31:2], 2'b00};
    bus.READ_ADDR = a;
    bus.READ_COUNT = n;
    bus.READ_REQ = 1'b1;
    @(negedge clk);
    check("accept_busy", 32'(bus.READ_BUSY), 32'd0);
    check("accept_state", 32'(dbg_state), 32'(ST_IDLE));
    for (int i = 0; i < int'(n); i++) exp_q.push_back(data_of(base + 32'(4 * i)));
    @(posedge clk); #1;
    bus.READ_REQ = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int cyc;
    cyc = 0;
    while (!(exp_q.size() == 0 && !bus.READ_BUSY && dbg_state == ST_IDLE) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc >= budget) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic check_ars(input vec_t v, input string tag);
    check({tag, "_ar_count"}, 32'(obs_addr.size()), 32'(v.n_ar));
    for (int j = 0; j < v.n_ar && j < obs_addr.size(); j++) begin
      check({tag, "_araddr"}, obs_addr[j], v.ar_addr[j]);
      check({tag, "_arlen"}, 32'(obs_len[j]), 32'(v.ar_len[j]));
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [15:0] n, input int k,
                              input logic [31:0] a0, input logic [7:0] l0,
                              input logic [31:0] a1, input logic [7:0] l1,
                              input logic [31:0] a2, input logic [7:0] l2);
    vec_t v;
    v.addr = a; v.count = n; v.n_ar = k;
    v.ar_addr[0] = a0; v.ar_len[0] = l0;
    v.ar_addr[1] = a1; v.ar_len[1] = l1;
    v.ar_addr[2] = a2; v.ar_len[2] = l2;
    return v;
  endfunction

  // AXI slave model: observes AR at negedge, returns beats of address-derived data.
  initial begin : axi_slave
    int wait_cnt;
    logic ar_fire, r_fire, rst_seen, err_due;
    wait_cnt = 0; err_due = 1'b0;
    bus.M_ARREADY = 1'b0; bus.M_RVALID = 1'b0; bus.M_RDATA = '0;
    bus.M_RRESP = 2'b00; bus.M_RLAST = 1'b0;
    forever begin
      @(negedge clk);
      rst_seen = rst;
      ar_fire = bus.M_ARVALID && bus.M_ARREADY && !rst;
      r_fire = bus.M_RVALID && !rst;
      if (hold_valid && !rst) begin
        check("ar_hold_valid", 32'(bus.M_ARVALID), 32'd1);
        check("ar_hold_addr", bus.M_ARADDR, hold_addr);
        check("ar_hold_len", 32'(bus.M_ARLEN), 32'(hold_len));
      end
      hold_valid = bus.M_ARVALID && !bus.M_ARREADY && !rst;
      hold_addr = bus.M_ARADDR;
      hold_len = bus.M_ARLEN;
`ifdef AXI_READ_STREAM_ERR_EN
      if (err_due) check("read_err_set", 32'(bus.READ_ERR), 32'd1);
      err_due = 1'b0;
      if (r_fire && bus.M_RRESP[1]) begin
        check("read_err_before", 32'(bus.READ_ERR), 32'd0);
        err_due = 1'b1;
      end
`endif
      if (ar_fire) begin
        obs_addr.push_back(bus.M_ARADDR);
        obs_len.push_back(bus.M_ARLEN);
        for (int i = 0; i <= int'(bus.M_ARLEN); i++) begin
          beat_q.push_back(bus.M_ARADDR + 32'(4 * i));
          last_q.push_back(i == int'(bus.M_ARLEN));
        end
      end
      @(posedge clk); #1;
      if (rst_seen) begin
        beat_q.delete(); last_q.delete();
        bus.M_RVALID = 1'b0; bus.M_RRESP = 2'b00; wait_cnt = 0;
      end else begin
        if (r_fire) begin
          void'(beat_q.pop_front());
          void'(last_q.pop_front());
          beats_fired++;
        end
        if (beat_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          bus.M_RVALID = 1'b1;
          bus.M_RDATA = data_of(beat_q[0]);
          bus.M_RLAST = last_q[0];
          bus.M_RRESP = (beats_fired == inject_at) ? 2'b10 : 2'b00;
        end else begin
          bus.M_RVALID = 1'b0;
          bus.M_RRESP = 2'b00;
        end
      end
      if (ar_delay == 0) bus.M_ARREADY = 1'b1;
      else begin
        if (ar_fire) wait_cnt = 0;
        else if (bus.M_ARVALID) wait_cnt++;
        bus.M_ARREADY = bus.M_ARVALID && !ar_fire && (wait_cnt >= ar_delay);
      end
    end
  end

  // Scoreboard: every popped word must match the head of the expected queue.
  initial begin : consumer
    forever begin
      @(negedge clk);
      if (!rst && bus.READ_VALID && bus.READ_READY) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL read_data_extra: got 0x%0h, expected no word", bus.READ_DATA);
        end else begin
          check("read_data", bus.READ_DATA, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int busy_cycles;
    vecs[0] = mk(32'h0000_1000, 16'd8, 1, 32'h1000, 8'd7, 32'h0, 8'd0, 32'h0, 8'd0);
    vecs[1] = mk(32'h0000_2000, 16'd40, 3, 32'h2000, 8'd15, 32'h2040, 8'd15, 32'h2080, 8'd7);
    vecs[2] = mk(32'h0000_0FF8, 16'd6, 2, 32'h0FF8, 8'd1, 32'h1000, 8'd3, 32'h0, 8'd0);
    vecs[3] = mk(32'h0000_3003, 16'd3, 1, 32'h3000, 8'd2, 32'h0, 8'd0, 32'h0, 8'd0);
    vecs[4] = mk(32'hFFFF_FFF8, 16'd4, 2, 32'hFFFF_FFF8, 8'd1, 32'h0000_0000, 8'd1, 32'h0, 8'd0);
    vecs[5] = mk(32'h0000_4FC0, 16'd20, 2, 32'h4FC0, 8'd15, 32'h5000, 8'd3, 32'h0, 8'd0);

    bus.READ_ADDR = '0; bus.READ_COUNT = '0; bus.READ_REQ = 1'b0; bus.READ_READY = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.READ_BUSY), 32'd0);
    check("rst_valid", 32'(bus.READ_VALID), 32'd0);
    check("rst_data", bus.READ_DATA, 32'd0);
    check("rst_arvalid", 32'(bus.M_ARVALID), 32'd0);
    check("rst_araddr", bus.M_ARADDR, 32'd0);
    check("rst_arlen", 32'(bus.M_ARLEN), 32'd0);
    check("rst_arsize", 32'(bus.M_ARSIZE), 32'd2);
    check("rst_arburst", 32'(bus.M_ARBURST), 32'd1);
`ifdef AXI_READ_STREAM_ERR_EN
    check("rst_err", 32'(bus.READ_ERR), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Busy window: CALC then ADDR with immediate ARREADY gives two busy cycles.
    obs_addr.delete(); obs_len.delete();
    do_req(32'h0000_1000, 16'd8);
    busy_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus.READ_BUSY) break;
      busy_cycles++;
    end
    check("busy_cycles", 32'(busy_cycles), 32'd2);
    @(posedge clk); #1;
    wait_drain(400);
    check_ars(vecs[0], "busy");

    for (int v = 0; v < 6; v++) begin
      obs_addr.delete(); obs_len.delete();
      do_req(vecs[v].addr, vecs[v].count);
      wait_drain(600);
      check_ars(vecs[v], $sformatf("vec%0d", v));
    end

    // Zero-length request is swallowed; the next one is accepted the very next cycle.
    obs_addr.delete(); obs_len.delete();
    do_req(32'h0000_5000, 16'd0);
    do_req(32'h0000_6000, 16'd2);
    wait_drain(200);
    check_ars(mk(32'h6000, 16'd2, 1, 32'h6000, 8'd1, 32'h0, 8'd0, 32'h0, 8'd0), "zero");

    // ARREADY held off for 5 cycles; the slave checks ARADDR/ARLEN stability each held cycle.
    obs_addr.delete(); obs_len.delete();
    ar_delay = 5;
    do_req(32'h0000_7000, 16'd4);
    wait_drain(200);
    check_ars(mk(32'h7000, 16'd4, 1, 32'h7000, 8'd3, 32'h0, 8'd0, 32'h0, 8'd0), "ardly");
    ar_delay = 0;
    @(posedge clk); #1;

    // Backpressure with a 32-word FIFO: two bursts fill it, the third waits for 16 pops.
    obs_addr.delete(); obs_len.delete();
    bus.READ_READY = 1'b0;
    do_req(32'h0000_8000, 16'd64);
    repeat (120) @(posedge clk);
    #1;
    check("bp_ar_count_full", 32'(obs_addr.size()), 32'd2);
    check("bp_state_calc", 32'(dbg_state), 32'(ST_CALC));
    check("bp_valid", 32'(bus.READ_VALID), 32'd1);
    check("bp_busy", 32'(bus.READ_BUSY), 32'd1);
    check("bp_rready", 32'(bus.M_RREADY), 32'd1);
    bus.READ_READY = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    bus.READ_READY = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check("bp_ar_count_after16", 32'(obs_addr.size()), 32'd3);
    check("bp_state_calc2", 32'(dbg_state), 32'(ST_CALC));
    bus.READ_READY = 1'b1;
    wait_drain(600);
    check("bp_ar_count_total", 32'(obs_addr.size()), 32'd4);
    if (obs_addr.size() >= 4) begin
      check("bp_araddr3", obs_addr[2], 32'h8080);
      check("bp_araddr4", obs_addr[3], 32'h80C0);
      check("bp_arlen4", 32'(obs_len[3]), 32'd15);
    end

    // Reset in the middle of a multi-burst request.
    obs_addr.delete(); obs_len.delete();
    do_req(32'h0000_9000, 16'd40);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mrst_busy", 32'(bus.READ_BUSY), 32'd0);
    check("mrst_valid", 32'(bus.READ_VALID), 32'd0);
    check("mrst_data", bus.READ_DATA, 32'd0);
    check("mrst_arvalid", 32'(bus.M_ARVALID), 32'd0);
    check("mrst_araddr", bus.M_ARADDR, 32'd0);
    check("mrst_arlen", 32'(bus.M_ARLEN), 32'd0);
    check("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    obs_addr.delete(); obs_len.delete();
    do_req(32'h0000_A000, 16'd5);
    wait_drain(200);
    check_ars(mk(32'hA000, 16'd5, 1, 32'hA000, 8'd4, 32'h0, 8'd0, 32'h0, 8'd0), "postrst");

`ifdef AXI_READ_STREAM_ERR_EN
    // Error response on the third beat; data still delivered, flag cleared by the next accept.
    check("err_clear_initial", 32'(bus.READ_ERR), 32'd0);
    inject_at = beats_fired + 2;
    do_req(32'h0000_B000, 16'd8);
    wait_drain(200);
    inject_at = -1;
    check("err_sticky", 32'(bus.READ_ERR), 32'd1);
    do_req(32'h0000_C000, 16'd2);
    @(negedge clk);
    check("err_cleared_on_accept", 32'(bus.READ_ERR), 32'd0);
    @(posedge clk); #1;
    wait_drain(200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_read_stream.md
Name: axi_read_stream

Overview:
- Read-side engine between the stencil coprocessor's read request interface and an AXI4 memory port.
- Accepts row requests (start address + word count) and splits each into AXI4 INCR bursts that never cross a 4 KB boundary.
- Buffers returned beats in an internal FIFO and presents them as a valid/ready word stream (READ_DATA/READ_VALID/READ_READY).

Parameters:
- MAX_BURST, 16, maximum beats per AR burst (power of 2, 1..256).
- FIFO_DEPTH, 512, data FIFO depth in 32-bit words (power of 2, >= 2*MAX_BURST).

Ports:
- CLK  in  1  clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- READ_ADDR  in  32  request byte address; bits [1:0] ignored (treated as 0).
- READ_COUNT  in  16  request length in 32-bit words.
- READ_REQ  in  1  request pending.
- READ_BUSY  out  1  request not accepted this cycle.
- READ_DATA  out  32  FIFO head word.
- READ_VALID  out  1  FIFO non-empty.
- READ_READY  in  1  consumer pops the head word.
- M_ARADDR  out  32  AXI read address.
- M_ARLEN  out  8  beats minus 1.
- M_ARSIZE  out  3  constant 3'b010.
- M_ARBURST  out  2  constant 2'b01 (INCR).
- M_ARVALID  out  1  AXI read-address valid.
- M_ARREADY  in  1  AXI read-address ready.
- M_RDATA  in  32  AXI read data.
- M_RRESP  in  2  AXI read response.
- M_RLAST  in  1  AXI last beat (not used for control).
- M_RVALID  in  1  AXI read-data valid.
- M_RREADY  out  1  constant 1.

Behaviour:
- Reset values: READ_BUSY=0, READ_VALID=0, READ_DATA=0, M_ARVALID=0, M_ARADDR=0, M_ARLEN=0. FIFO and all counters are cleared.
- Request accept: a request is accepted on a cycle with READ_REQ=1 and READ_BUSY=0. On that edge, addr <= {READ_ADDR[31:2],2'b00} and remaining <= READ_COUNT.
- READ_BUSY is registered:
  - It is 1 from the cycle after accept until the cycle after the final AR handshake of that request.
  - Back-to-back requests are therefore separated by at least one cycle.
  - Data of the previous request may still be returning when the next request is accepted.
- FSM states:
  - IDLE: BUSY=0. On accept go to CALC, or stay in IDLE if READ_COUNT=0 (zero-length request is consumed with no AR).
  - CALC: compute len = min(remaining, MAX_BURST, (4096 - addr[11:0])/4).
    - If reserve + len <= FIFO_DEPTH: reserve += len and go to ADDR.
    - Otherwise stay in CALC (wait for space).
  - ADDR: M_ARVALID=1 with ARADDR=addr and ARLEN=len-1. These outputs are held stable until M_ARREADY.
    - On the handshake: addr += 4*len; remaining -= len.
    - Then go to CALC if remaining != 0, else IDLE.
- Space reservation: reserve counts words in the FIFO plus beats requested but not yet arrived.
  - Increment by len when CALC exits to ADDR; decrement by 1 on each FIFO pop.
  - Reserve and pop in the same cycle net correctly.
  - Consequence: the FIFO never overflows, so M_RREADY is tied to 1.
- Every M_RVALID beat is written into the FIFO. M_RLAST is not used for control.
- FIFO:
  - First-word fall-through: READ_DATA is the head word and READ_VALID = ~empty.
  - A pop occurs on READ_VALID & READ_READY.
  - Simultaneous push and pop when full or empty is legal. A push into an empty FIFO appears on READ_VALID in the next cycle (1-cycle latency).
- Address arithmetic: 32-bit, wraps modulo 2^32. Bursts are split so that 4 KB pages are never crossed.
- Mid-operation reset: the FSM returns to IDLE and the FIFO, reserve and addr are cleared. The AXI slave must be reset in the same cycle.

Optional Feature:
- Macro: AXI_READ_STREAM_ERR_EN.
- Defined:
  - Adds output READ_ERR (1 bit, reset 0).
  - READ_ERR is set sticky on any beat with M_RVALID=1 and M_RRESP[1]=1.
  - It is cleared on the next request accept; a set in the same cycle as an accept wins.
  - The errored data is still pushed into the FIFO.
- Not defined: no READ_ERR port and M_RRESP is ignored.

Test Plan:
- Single short request: ADDR=0x1000, COUNT=8, READ_READY=1 → one AR (ARADDR=0x1000, ARLEN=7); 8 words exit in order; BUSY high for exactly the cycles up to one after the AR handshake.
- Long request: COUNT=40, MAX_BURST=16, ADDR=0x2000 → ARLEN sequence 15, 15, 7 at 0x2000, 0x2040, 0x2080; 40 words in order.
- 4 KB crossing: ADDR=0x0FF8, COUNT=6 → AR(0x0FF8, ARLEN=1) then AR(0x1000, ARLEN=3).
- Backpressure: FIFO_DEPTH=32, READ_READY=0, COUNT=64 → two 16-beat ARs issued, the third stalls in CALC. After 16 pops the next AR issues; no beat is lost and M_RREADY stays 1.
- Edge cases:
  - COUNT=0 → no AR, stays in IDLE, next request accepted normally.
  - ARREADY delayed 5 cycles → ARADDR/ARLEN stay stable throughout.
  - RST asserted mid-burst → all outputs return to reset values on the next edge.
- Compiled with AXI_READ_STREAM_ERR_EN: inject RRESP=2'b10 on beat 3 → READ_ERR=1 from the next cycle; it clears on the next accept.
